i2s_rx_deserializer: RTL and testbench
======================================

# i2s_rx_deserializer

Receive-side I2S stage downstream of the I2S clock divider. It samples the ADC serial data line on rising edges of the divider's `sclk`, using `lrclk` to frame the channels, and produces one left/right sample pair per audio frame as parallel words with a single-cycle valid strobe. It runs entirely in the `mclk` domain. `sclk` and `lrclk` are registered outputs of the divider in that same domain, so they are treated as synchronous enables, not as clocks.

## Interface
- `DATA_W`, 24: sample width in bits; the first `DATA_W` bits after the MSB position are kept.
- `SLOT_W`, 32: `sclk` periods per channel slot (64 per frame).
- Clock and reset: one clock; reset is asynchronous and active-low.
- `mclk`  in  1  master clock, the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `sclk`  in  1  bit clock from the divider, synchronous to `mclk`.
- `lrclk`  in  1  word select from the divider; 0 = left, 1 = right.
- `sdata`  in  1  serial data from the ADC, driven on `sclk` falling edges.
- `left_out`  out  DATA_W  left sample, two's complement.
- `right_out`  out  DATA_W  right sample, two's complement.
- `sample_valid`  out  1  one-`mclk` pulse when a new pair is presented.
- `frame_err`  out  1  one-`mclk` pulse on a slot-length violation; constant 0 when the check is compiled out.

## Operation
- **Edge detect:** `sclk_q` registers `sclk`. A rise is the cycle with `sclk`=1 and `sclk_q`=0. All state below advances only on rise cycles.
- **Capture:** on each rise, register `ws_p1` <= `lrclk` and `ws_p2` <= `ws_p1`. `sdata` is sampled in the same cycle.
- **One-bit I2S delay:**
  - The captured bit belongs to channel `ws_p1` (the value before the update).
  - A slot starts when `ws_p1` != `ws_p2`.
- **Bit counter:**
  - Set to 0 on slot start; otherwise increment, saturating at `SLOT_W`-1.
  - While the index is < `DATA_W`, shift the bit MSB-first into that channel's shift register.
  - Bits at index ≥ `DATA_W` are ignored.
- **Word complete:** when the index reaches `DATA_W`-1:
  - Left: copy the shift register into a left holding register.
  - Right: load `left_out` <= left holding and `right_out` <= right shift value, and pulse `sample_valid` once.
- **Sync:**
  - After reset, the `locked` flag is 0 and captures are discarded.
  - `locked` sets on the first left slot start (1→0 on `lrclk`).
  - A right word with no preceding complete left word in the same frame produces no `sample_valid`.
- `sdata` is not synchronised. It is stable around `sclk` rises by construction.
- **Requirement on sources:** `sclk` must stay high and low for at least 1 `mclk` cycle each. At the divider's mclk/8 ratio each phase is 4 cycles.

## Timing
- **Reset values:** `left_out`=0, `right_out`=0, `sample_valid`=0, `frame_err`=0, counter 0, `locked`=0, `ws_p1`=`ws_p2`=0.
- **Reset mid-frame:** the partial frame is discarded. The first valid pair is the first full left+right frame after the next left slot start.
- **Valid latency:** `sample_valid` is high in the `mclk` cycle after the rise cycle that captures right bit `DATA_W`-1.
  - `left_out` and `right_out` change in that same cycle and hold until the next pulse.
- `sample_valid` is never high for two consecutive cycles. It occurs at most once per frame.
- **Slot start at counter 0:** a slot start while the counter is already 0 (a `lrclk` glitch) restarts the slot.

## Configuration
- Macro: `I2S_RX_FRAME_CHECK_EN`.
- **Defined:**
  - On every slot start while `locked`, the previous slot's final counter value must equal `SLOT_W`-1. Otherwise pulse `frame_err` for one cycle.
  - Any error during a frame suppresses that frame's `sample_valid` and clears the left holding register.
- **Not defined:**
  - No check is made, and `frame_err` is tied to 0.
  - Short slots still complete if they reach `DATA_W` bits.

## Structure
- Package `i2s_pkg` holds:
  - default `DATA_W` and `SLOT_W` as localparams;
  - `typedef enum logic {CH_LEFT=1'b0, CH_RIGHT=1'b1} i2s_ch_t`;
  - `typedef logic signed [DATA_W-1:0] i2s_sample_t`.
- One sub-module is natural: `i2s_edge_detect`, the `sclk` rise/fall pulse generator. It will be reused by the transmitter stage.
- The bit counter and shift registers stay inline.

## Test plan
- **Basic pair:**
  - Stimulus: the divider drives `mclk`/8 `sclk` and `lrclk` with 32 bits per slot; left = 0x123456, right = 0xABCDEF.
  - Response: one `sample_valid` per frame with `left_out`=0x123456 and `right_out`=0xABCDEF.
- **Negative full scale:**
  - Stimulus: left = 0x800000, right = 0x7FFFFF.
  - Response: outputs match exactly.
  - Trailing bits 24..31 driven to 1 do not alter the result.
- **Start-up:**
  - Stimulus: release reset mid right slot.
  - Response: no `sample_valid` until after the first complete left+right frame.
  - All outputs read 0 before that.
- **Reset mid-frame:**
  - Stimulus: assert `rst`=0 for 3 `mclk` cycles during left bit 10.
  - Response: outputs return to 0 asynchronously, and the next pair is valid one full frame later.
- **Short slot (macro defined):**
  - Stimulus: make one left slot 30 bits long.
  - Response: one `frame_err` pulse at the right slot start, and no `sample_valid` for that frame.
  - The following frame is valid.
- **Same short slot (macro undefined):** `frame_err` stays 0, and the pair is still delivered.

Source files
------------

// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S receive/transmit stages.
//   DATA_W       : default sample width in bits
//   SLOT_W       : default sclk periods per channel slot (two slots per frame)
//   i2s_ch_t     : channel encoding, matching the lrclk level of the slot
//   i2s_sample_t : signed sample word of the default width
// ---------------------------------------------------------------------------
package i2s_pkg;

    localparam int DATA_W = 24;
    localparam int SLOT_W = 32;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_ch_t;

    typedef logic signed [DATA_W-1:0] i2s_sample_t;

endpackage

// File: rtl/i2s_edge_detect.sv
// ---------------------------------------------------------------------------
// i2s_edge_detect
// Turns a level that is synchronous to i_clk (such as the divider's sclk)
// into single-cycle rise and fall pulses. The pulses are combinational from
// the current level and the registered previous level, so they are valid in
// the same cycle the new level is first seen.
// Ports:
//   i_clk   : clock the level is synchronous to
//   i_rst_n : asynchronous active-low reset (previous level resets to 0)
//   i_sig   : level to watch
//   o_rise  : high for the cycle where i_sig is 1 and was 0
//   o_fall  : high for the cycle where i_sig is 0 and was 1
// ---------------------------------------------------------------------------
module i2s_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_sig_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sig_q <= 1'b0;
        end else begin
            r_sig_q <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_q;
    assign o_fall = ~i_sig & r_sig_q;

endmodule

// File: rtl/i2s_rx_deserializer.sv
// ---------------------------------------------------------------------------
// i2s_rx_deserializer
// Receives I2S serial audio in the mclk domain. sclk and lrclk are treated
// as synchronous enables; all framing state advances only on sclk rise
// cycles. One left/right pair is presented per frame with a one-cycle
// sample_valid strobe.
//
// Build option: define I2S_RX_FRAME_CHECK_EN to enable the slot-length
// check (frame_err pulses and the faulty frame is dropped). Without it
// frame_err is tied to 0 and short slots still deliver if they carry at
// least DATA_W bits.
//
// Ports:
//   mclk         : master clock (the only clock)
//   rst          : asynchronous active-low reset
//   sclk         : bit clock level from the divider
//   lrclk        : word select, 0 = left, 1 = right
//   sdata        : serial data, MSB first, one sclk after lrclk changes
//   left_out     : left sample (two's complement)
//   right_out    : right sample (two's complement)
//   sample_valid : one-cycle pulse when left_out/right_out are updated
//   frame_err    : one-cycle pulse on a slot-length violation
// ---------------------------------------------------------------------------
module i2s_rx_deserializer #(
    parameter int DATA_W = i2s_pkg::DATA_W,
    parameter int SLOT_W = i2s_pkg::SLOT_W
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              lrclk,
    input  logic              sdata,
    output logic [DATA_W-1:0] left_out,
    output logic [DATA_W-1:0] right_out,
    output logic              sample_valid,
    output logic              frame_err
);

    import i2s_pkg::*;

    localparam int CNT_W  = $clog2(SLOT_W);
    localparam int CNT_W1 = CNT_W + 1;
    localparam logic [CNT_W-1:0] C_SLOT_LAST = CNT_W'(SLOT_W - 1);
    localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W:0]   C_DATA_W    = CNT_W1'(DATA_W);

    logic              r_ws_p1;
    logic              r_ws_p2;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_locked;
    logic              r_left_ok;     // a complete left word is held for this frame
    logic [DATA_W-1:0] r_sr_l;
    logic [DATA_W-1:0] r_sr_r;
    logic [DATA_W-1:0] r_left_hold;
    logic              r_frame_err;

    logic              w_rise;
    logic              w_slot_start;
    logic              w_left_start;
    logic              w_active;
    logic              w_in_word;
    logic              w_word_done;
    logic              w_err;
    i2s_ch_t           w_ch;
    logic [CNT_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_sr_l_next;
    logic [DATA_W-1:0] w_sr_r_next;

    i2s_edge_detect u_sclk_edge (
        .i_clk   (mclk),
        .i_rst_n (rst),
        .i_sig   (sclk),
        .o_rise  (w_rise),
        .o_fall  ()
    );

    // The I2S one-bit delay: the bit sampled on this rise belongs to the
    // channel lrclk selected on the previous rise, and a slot begins when
    // that value differs from the one before it.
    assign w_slot_start = r_ws_p1 ^ r_ws_p2;
    assign w_ch         = i2s_ch_t'(r_ws_p1);
    assign w_left_start = w_slot_start && (w_ch == CH_LEFT);
    // The capture that sets lock is the MSB of the first usable left word.
    assign w_active     = r_locked || w_left_start;

    // Bit index of the current capture; saturates so oversized slots hold.
    always_comb begin
        w_idx = r_cnt;
        if (w_slot_start) begin
            w_idx = '0;
        end else if (r_cnt != C_SLOT_LAST) begin
            w_idx = r_cnt + 1'b1;
        end
    end

    assign w_in_word   = ({1'b0, w_idx} < C_DATA_W);
    assign w_word_done = (w_idx == C_DATA_LAST);
    assign w_sr_l_next = {r_sr_l[DATA_W-2:0], sdata};
    assign w_sr_r_next = {r_sr_r[DATA_W-2:0], sdata};

`ifdef I2S_RX_FRAME_CHECK_EN
    // r_cnt still holds the final index of the slot that is ending.
    assign w_err = w_rise && w_slot_start && r_locked && (r_cnt != C_SLOT_LAST);
`else
    assign w_err = 1'b0;
`endif

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            r_ws_p1      <= 1'b0;
            r_ws_p2      <= 1'b0;
            r_cnt        <= '0;
            r_locked     <= 1'b0;
            r_left_ok    <= 1'b0;
            r_sr_l       <= '0;
            r_sr_r       <= '0;
            r_left_hold  <= '0;
            r_frame_err  <= 1'b0;
            left_out     <= '0;
            right_out    <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            r_frame_err  <= w_err;
            if (w_rise) begin
                r_ws_p1 <= lrclk;
                r_ws_p2 <= r_ws_p1;
                r_cnt   <= w_idx;
                if (w_left_start) begin
                    r_locked  <= 1'b1;
                    r_left_ok <= 1'b0;
                end
                // A bad slot poisons the frame it is part of.
                if (w_err) begin
                    r_left_ok   <= 1'b0;
                    r_left_hold <= '0;
                end
                if (w_active && w_in_word) begin
                    if (w_ch == CH_LEFT) begin
                        r_sr_l <= w_sr_l_next;
                        if (w_word_done) begin
                            r_left_hold <= w_sr_l_next;
                            r_left_ok   <= 1'b1;
                        end
                    end else begin
                        r_sr_r <= w_sr_r_next;
                        if (w_word_done) begin
                            r_left_ok <= 1'b0;
                            if (r_left_ok) begin
                                left_out     <= r_left_hold;
                                right_out    <= w_sr_r_next;
                                sample_valid <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx_deserializer
// Drives I2S frames (sclk = mclk/8, lrclk and sdata changing on sclk falling
// edges, data one bit behind lrclk) described as lists of slots. Expected
// pairs come from a directed table or from a slot-level reference model;
// received pairs and frame_err pulses are collected by a monitor and compared
// at the end of each scenario.
// ---------------------------------------------------------------------------
module tb_i2s_rx_deserializer;

    localparam int DATA_W = 24;
    localparam int SLOT_W = 32;
`ifdef I2S_RX_FRAME_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic              mclk = 1'b0;
    logic              rst = 1'b1;
    logic              sclk = 1'b0;
    logic              lrclk = 1'b0;
    logic              sdata = 1'b0;
    logic [DATA_W-1:0] left_out;
    logic [DATA_W-1:0] right_out;
    logic              sample_valid;
    logic              frame_err;

    always #5 mclk = ~mclk;

    i2s_rx_deserializer #(
        .DATA_W (DATA_W),
        .SLOT_W (SLOT_W)
    ) dut (
        .mclk         (mclk),
        .rst          (rst),
        .sclk         (sclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .left_out     (left_out),
        .right_out    (right_out),
        .sample_valid (sample_valid),
        .frame_err    (frame_err)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        bit                ch;
        int                len;
        logic [DATA_W-1:0] word;
        bit                fill;
    } slot_t;

    typedef struct {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
        int                l_len;
        bit                fill;
        bit                exp_valid;
        logic [DATA_W-1:0] exp_l;
        logic [DATA_W-1:0] exp_r;
        int                exp_err;
    } vec_t;

    slot_t                slots[$];
    logic [2*DATA_W-1:0]  exp_q[$];
    logic [2*DATA_W-1:0]  got_q[$];
    int                   exp_err = 0;
    int                   err_seen = 0;
    int                   period_n = -1;
    bit                   drv_done = 1'b0;
    bit                   prev_valid = 1'b0;

    // ---------------- monitor ----------------
    always @(negedge mclk) begin
        if (sample_valid) begin
            got_q.push_back({left_out, right_out});
            check("valid_single_cycle", 64'(prev_valid), 64'd0);
        end
        if (frame_err) err_seen++;
        prev_valid = sample_valid;
    end

    // ---------------- driver ----------------
    function automatic void add_slot(input bit ch, input int len, input logic [DATA_W-1:0] w, input bit fill);
        slot_t s;
        s.ch = ch;
        s.len = len;
        s.word = w;
        s.fill = fill;
        slots.push_back(s);
    endfunction

    task automatic drive_stream();
        bit lr_q[$];
        bit d_q[$];
        d_q.push_back(1'b0);
        foreach (slots[i]) begin
            for (int k = 0; k < slots[i].len; k++) begin
                lr_q.push_back(slots[i].ch);
                d_q.push_back(k < DATA_W ? slots[i].word[DATA_W-1-k] : slots[i].fill);
            end
        end
        lr_q.push_back(slots[slots.size()-1].ch);
        for (int n = 0; n < lr_q.size(); n++) begin
            @(negedge mclk);
            sclk = 1'b0;
            lrclk = lr_q[n];
            sdata = d_q[n];
            period_n = n;
            repeat (4) @(negedge mclk);
            sclk = 1'b1;
            repeat (3) @(negedge mclk);
        end
        drv_done = 1'b1;
    endtask

    // ---------------- reference model ----------------
    // Works slot by slot: lock on the first right->left change seen after
    // reset, a left word is usable once DATA_W bits arrived, a following
    // right word with DATA_W bits yields a pair. With the check built in,
    // every locked slot start after a slot that was not SLOT_W long is an
    // error and drops that frame. A slot containing the reset is lost.
    function automatic int model(input int rst_p);
        int                s = 0;
        int                errs = 0;
        int                len;
        bit                ch;
        bit                locked = 1'b0;
        bit                left_ok = 1'b0;
        logic [DATA_W-1:0] lv = '0;
        for (int i = 0; i < slots.size(); i++) begin
            len = slots[i].len;
            ch = slots[i].ch;
            if (rst_p >= s + 1 && rst_p <= s + len - 1) begin
                locked = 1'b0;
                left_ok = 1'b0;
            end else begin
                if (i > 0 && locked && CHK && slots[i-1].len != SLOT_W) begin
                    errs++;
                    left_ok = 1'b0;
                end
                if (!ch && i > 0 && slots[i-1].ch) begin
                    locked = 1'b1;
                    left_ok = 1'b0;
                end
                if (locked) begin
                    if (!ch) begin
                        left_ok = (len >= DATA_W);
                        lv = slots[i].word;
                    end else begin
                        if (left_ok && len >= DATA_W) exp_q.push_back({lv, slots[i].word});
                        left_ok = 1'b0;
                    end
                end
            end
            s += len;
        end
        return errs;
    endfunction

    // ---------------- scenario runner ----------------
    task automatic compare(input string tag);
        int n;
        check({tag, "_pair_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_left"}, 64'(got_q[i][2*DATA_W-1:DATA_W]), 64'(exp_q[i][2*DATA_W-1:DATA_W]));
            check({tag, "_right"}, 64'(got_q[i][DATA_W-1:0]), 64'(exp_q[i][DATA_W-1:0]));
        end
        check({tag, "_frame_err_count"}, 64'(err_seen), 64'(exp_err));
        exp_q.delete();
        slots.delete();
    endtask

    task automatic run(input string tag, input bit hold, input int rst_p, input int probe_p);
        @(negedge mclk);
        rst = 1'b0;
        sclk = 1'b0;
        lrclk = 1'b0;
        sdata = 1'b0;
        repeat (4) @(negedge mclk);
        got_q.delete();
        err_seen = 0;
        drv_done = 1'b0;
        period_n = -1;
        if (!hold) rst = 1'b1;
        repeat (2) @(negedge mclk);
        fork
            drive_stream();
            begin
                wait ((rst_p >= 0 && period_n == rst_p) || drv_done);
                if (!drv_done) begin
                    rst = 1'b0;
                    #1;
                    check({tag, "_async_rst_left"}, 64'(left_out), 64'd0);
                    check({tag, "_async_rst_right"}, 64'(right_out), 64'd0);
                    repeat (3) @(negedge mclk);
                    rst = 1'b1;
                end
            end
            begin
                wait ((probe_p >= 0 && period_n == probe_p) || drv_done);
                if (!drv_done) begin
                    check({tag, "_early_left"}, 64'(left_out), 64'd0);
                    check({tag, "_early_right"}, 64'(right_out), 64'd0);
                    check({tag, "_early_valid"}, 64'(got_q.size()), 64'd0);
                end
            end
        join
        repeat (16) @(negedge mclk);
        compare(tag);
    endtask

    task automatic random_frames(input int n_frames);
        add_slot(1'b0, SLOT_W, DATA_W'($urandom()), 1'b0);
        add_slot(1'b1, SLOT_W, DATA_W'($urandom()), 1'b0);
        for (int f = 0; f < n_frames; f++) begin
            add_slot(1'b0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 31)) : SLOT_W,
                     DATA_W'($urandom()), 1'($urandom_range(0, 1)));
            add_slot(1'b1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 31)) : SLOT_W,
                     DATA_W'($urandom()), 1'($urandom_range(0, 1)));
        end
        add_slot(1'b0, SLOT_W, DATA_W'($urandom()), 1'b0);
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs[6];

    initial begin
        vecs[0] = '{24'h123456, 24'hABCDEF, 32, 1'b0, 1'b1, 24'h123456, 24'hABCDEF, 0};
        vecs[1] = '{24'h800000, 24'h7FFFFF, 32, 1'b1, 1'b1, 24'h800000, 24'h7FFFFF, 0};
        vecs[2] = '{24'h7FFFFF, 24'h800000, 32, 1'b1, 1'b1, 24'h7FFFFF, 24'h800000, 0};
        vecs[3] = '{24'h000001, 24'hFFFFFF, 32, 1'b0, 1'b1, 24'h000001, 24'hFFFFFF, 0};
        vecs[4] = '{24'h5A5A5A, 24'hA5A5A5, 30, 1'b0, !CHK, 24'h5A5A5A, 24'hA5A5A5, CHK ? 1 : 0};
        vecs[5] = '{24'h123456, 24'hABCDEF, 32, 1'b1, 1'b1, 24'h123456, 24'hABCDEF, 0};

        // Reset state
        #2 rst = 1'b0;
        #1;
        check("reset_left_out", 64'(left_out), 64'd0);
        check("reset_right_out", 64'(right_out), 64'd0);
        check("reset_sample_valid", 64'(sample_valid), 64'd0);
        check("reset_frame_err", 64'(frame_err), 64'd0);

        // Directed table: unlocked preamble, then one frame per vector
        add_slot(1'b0, SLOT_W, 24'h0F0F0F, 1'b0);
        add_slot(1'b1, SLOT_W, 24'hF0F0F0, 1'b0);
        exp_err = 0;
        for (int i = 0; i < 6; i++) begin
            add_slot(1'b0, vecs[i].l_len, vecs[i].l, vecs[i].fill);
            add_slot(1'b1, SLOT_W, vecs[i].r, vecs[i].fill);
            if (vecs[i].exp_valid) exp_q.push_back({vecs[i].exp_l, vecs[i].exp_r});
            exp_err += vecs[i].exp_err;
        end
        add_slot(1'b0, SLOT_W, 24'h000000, 1'b0);
        run("table", 1'b0, -1, -1);

        // Start-up: reset released in the middle of a right slot
        add_slot(1'b1, SLOT_W, 24'h111111, 1'b1);
        add_slot(1'b0, SLOT_W, 24'h2468AC, 1'b0);
        add_slot(1'b1, SLOT_W, 24'h13579B, 1'b1);
        add_slot(1'b0, SLOT_W, 24'h0F0F0F, 1'b0);
        add_slot(1'b1, SLOT_W, 24'hF0F0F0, 1'b0);
        add_slot(1'b0, SLOT_W, 24'h000000, 1'b0);
        exp_err = model(12);
        run("startup", 1'b1, 12, 2 * SLOT_W + 10);

        // Reset for 3 cycles during left bit 10 of the third frame
        add_slot(1'b0, SLOT_W, 24'hAAAAAA, 1'b0);
        add_slot(1'b1, SLOT_W, 24'h555555, 1'b0);
        add_slot(1'b0, SLOT_W, 24'hC0FFEE, 1'b1);
        add_slot(1'b1, SLOT_W, 24'hBADA55, 1'b1);
        add_slot(1'b0, SLOT_W, 24'h999999, 1'b0);
        add_slot(1'b1, SLOT_W, 24'h666666, 1'b0);
        add_slot(1'b0, SLOT_W, 24'h3C3C3C, 1'b1);
        add_slot(1'b1, SLOT_W, 24'hC3C3C3, 1'b0);
        add_slot(1'b0, SLOT_W, 24'h000000, 1'b0);
        exp_err = model(4 * SLOT_W + 11);
        run("midreset", 1'b0, 4 * SLOT_W + 11, -1);

        // Randomized frames with occasional short slots
        for (int r = 0; r < 3; r++) begin
            random_frames(6);
            exp_err = model(-1);
            run("random", 1'b0, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound on total run time
    initial begin
        #2000000;
        $display("FAIL timeout got %0d checks expected completion", checks);
        $fatal(1, "timeout");
    end

endmodule
